// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller.
// The in-flight scoreboard entry and register match rule live here.
package hazard_pkg;

    // Register fields are stored zero-extended so the entry type is parameter-free.
    localparam int unsigned MAX_REG_AW = 8;
    localparam int unsigned FWD_RF     = 0;

    typedef logic [MAX_REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        logic      wr_en;
        logic      is_load;
        reg_addr_t dst;
        reg_addr_t rs;
        reg_addr_t rt;
        logic      rs_used;
        logic      rt_used;
    } sb_entry_t;

    function automatic int unsigned fs_w(input int unsigned stages);
        return (stages < 1) ? 1 : $clog2(stages + 1);
    endfunction

    // Register 0 is hard-wired and never produces a dependency.
    function automatic logic sb_match(input sb_entry_t e, input reg_addr_t r);
        return e.valid & e.wr_en & (e.dst == r) & (r != '0);
    endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Priority matcher for one EX source operand over scoreboard entries 1..FWD_STAGES.
// The youngest producer wins; loads too young to have data are never selected.
module hazard_fwd_match
    import hazard_pkg::*;
#(
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned FS_W       = fs_w(FWD_STAGES)
) (
    input  sb_entry_t        sb [FWD_STAGES+1],
    input  reg_addr_t        src,
    input  logic             used,
    output logic [FS_W-1:0]  sel
);

    always_comb begin
        sel = FS_W'(FWD_RF);
        // Walk oldest to youngest so the smallest matching index is left in sel.
        for (int k = int'(FWD_STAGES); k >= 1; k--) begin
            if (used && sb_match(sb[k], src) && !(sb[k].is_load && k < int'(LOAD_LAT) + 1)) begin
                sel = FS_W'(k);
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and forwarding controller for the 5-stage pipeline.
// Define HAZARD_STATS_EN to add saturating stall/flush event counters.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned FWD_STAGES = 2,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned BR_STAGE   = 1,
    parameter int unsigned FS_W       = fs_w(FWD_STAGES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              redirect,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic [BR_STAGE+1:0] flush_mask,
    output logic [FS_W-1:0]   fwd_a_sel,
    output logic [FS_W-1:0]   fwd_b_sel,
    output logic              id_bypass_a,
    output logic              id_bypass_b
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_events
`endif
);

    sb_entry_t sb_q [FWD_STAGES+1];
    sb_entry_t sb_d [FWD_STAGES+1];

    reg_addr_t rs_x, rt_x, dst_x;
    logic      load_use, redirect_act, stall;

    assign rs_x  = reg_addr_t'(id_rs);
    assign rt_x  = reg_addr_t'(id_rt);
    assign dst_x = reg_addr_t'(id_dst);

    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            if (sb_q[k].is_load &&
                ((id_rs_used && sb_match(sb_q[k], rs_x)) ||
                 (id_rt_used && sb_match(sb_q[k], rt_x)))) begin
                load_use = 1'b1;
            end
        end
    end

    // The scoreboard clears asynchronously, so only redirect needs gating to hold outputs at 0.
    assign redirect_act = rst_n & redirect;
    assign stall        = id_valid & load_use & ~redirect_act;

    assign stall_if_id  = stall;
    assign bubble_id_ex = stall | redirect_act;
    assign flush_mask   = {(BR_STAGE + 2){redirect_act}};
    assign id_bypass_a  = id_rs_used & sb_match(sb_q[FWD_STAGES], rs_x);
    assign id_bypass_b  = id_rt_used & sb_match(sb_q[FWD_STAGES], rt_x);

    always_comb begin
        sb_d[0] = '0;
        if (id_valid && !stall && !redirect_act) begin
            sb_d[0].valid   = 1'b1;
            sb_d[0].wr_en   = id_wr_en;
            sb_d[0].is_load = id_is_load;
            sb_d[0].dst     = dst_x;
            sb_d[0].rs      = rs_x;
            sb_d[0].rt      = rt_x;
            sb_d[0].rs_used = id_rs_used;
            sb_d[0].rt_used = id_rt_used;
        end
        // Instructions younger than the resolving branch are wrong-path and die as they shift.
        for (int k = 1; k <= int'(FWD_STAGES); k++) begin
            sb_d[k] = (redirect_act && k <= int'(BR_STAGE)) ? '0 : sb_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= int'(FWD_STAGES); k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    hazard_fwd_match #(
        .FWD_STAGES (FWD_STAGES),
        .LOAD_LAT   (LOAD_LAT),
        .FS_W       (FS_W)
    ) u_fwd_a (
        .sb   (sb_q),
        .src  (sb_q[0].rs),
        .used (sb_q[0].valid & sb_q[0].rs_used),
        .sel  (fwd_a_sel)
    );

    hazard_fwd_match #(
        .FWD_STAGES (FWD_STAGES),
        .LOAD_LAT   (LOAD_LAT),
        .FS_W       (FS_W)
    ) u_fwd_b (
        .sb   (sb_q),
        .src  (sb_q[0].rt),
        .used (sb_q[0].valid & sb_q[0].rt_used),
        .sel  (fwd_b_sel)
    );

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect_act && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif

endmodule
